// File: rtl/fp7_alu_align_stage_if.sv
// Operand-side and result-side valid/ready bundle of the fp7 align stage.
// The stage uses the slave modport; the operand source and result sink together form the master side.
interface fp7_alu_align_stage_if #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 24
);
    logic                             i_valid;
    logic                             i_ready;
    logic        [EXPONENT_WIDTH-1:0] i_exponent_a;
    logic        [EXPONENT_WIDTH-1:0] i_exponent_b;
    logic signed [MANTISSA_WIDTH-1:0] i_mantissa_a;
    logic signed [MANTISSA_WIDTH-1:0] i_mantissa_b;
    logic                             o_valid;
    logic                             o_ready;
    logic                             o_exponent_big_a;
    logic        [EXPONENT_WIDTH-1:0] o_exponent_big;
    logic signed [MANTISSA_WIDTH-1:0] mantissa_big_out;
    logic signed [MANTISSA_WIDTH-1:0] mantissa_aligned;

    modport master (
        output i_valid, i_exponent_a, i_exponent_b, i_mantissa_a, i_mantissa_b, o_ready,
        input  i_ready, o_valid, o_exponent_big_a, o_exponent_big, mantissa_big_out, mantissa_aligned
    );

    modport slave (
        input  i_valid, i_exponent_a, i_exponent_b, i_mantissa_a, i_mantissa_b, o_ready,
        output i_ready, o_valid, o_exponent_big_a, o_exponent_big, mantissa_big_out, mantissa_aligned
    );
endinterface

// File: rtl/fp7_alu_align_stage.sv
// fp7 adder front end: exponent compare (stage 1) and arithmetic mantissa alignment (stage 2).
// Define FP7_ALIGN_STICKY_EN to OR the shifted-out bits into bit 0 of the aligned mantissa.
module fp7_alu_align_stage #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 24
) (
    input logic                 clk,
    input logic                 rst,
    fp7_alu_align_stage_if.slave bus
);
    // Handshake: a pair moves across a boundary at a rising edge where valid and ready are
    // both high; valid and its data hold until then. i_ready depends combinationally on o_ready.
    logic                             v1;
    logic                             v2;
    logic                             s1_load;
    logic                             s2_load;
    logic                             ready1;

    logic                             big_a_c;
    logic        [EXPONENT_WIDTH-1:0] diff_c;

    logic                             big_a1;
    logic        [EXPONENT_WIDTH-1:0] exp_big1;
    logic        [EXPONENT_WIDTH-1:0] diff1;
    logic signed [MANTISSA_WIDTH-1:0] man_big1;
    logic signed [MANTISSA_WIDTH-1:0] man_small1;

    logic                             sat;
    logic signed [MANTISSA_WIDTH-1:0] shifted;
    logic signed [MANTISSA_WIDTH-1:0] aligned_next;
`ifdef FP7_ALIGN_STICKY_EN
    logic        [MANTISSA_WIDTH-1:0] lost_mask;
`endif

    logic                             big_a2;
    logic        [EXPONENT_WIDTH-1:0] exp_big2;
    logic signed [MANTISSA_WIDTH-1:0] man_big2;
    logic signed [MANTISSA_WIDTH-1:0] aligned2;

    assign s2_load = v1 & (~v2 | bus.o_ready);
    assign ready1  = ~v1 | s2_load;
    assign s1_load = bus.i_valid & ready1;

    // Tie goes to A so the difference is always non-negative.
    assign big_a_c = (bus.i_exponent_a >= bus.i_exponent_b);
    assign diff_c  = big_a_c ? (bus.i_exponent_a - bus.i_exponent_b)
                             : (bus.i_exponent_b - bus.i_exponent_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (s1_load)      v1 <= 1'b1;
            else if (s2_load) v1 <= 1'b0;
            if (s2_load)          v2 <= 1'b1;
            else if (bus.o_ready) v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            big_a1     <= big_a_c;
            exp_big1   <= big_a_c ? bus.i_exponent_a : bus.i_exponent_b;
            diff1      <= diff_c;
            man_big1   <= big_a_c ? bus.i_mantissa_a : bus.i_mantissa_b;
            man_small1 <= big_a_c ? bus.i_mantissa_b : bus.i_mantissa_a;
        end
    end

    assign sat = (32'(diff1) >= 32'(MANTISSA_WIDTH));

    always_comb begin
        shifted = man_small1 >>> diff1;
        if (sat) shifted = {MANTISSA_WIDTH{man_small1[MANTISSA_WIDTH-1]}};
`ifdef FP7_ALIGN_STICKY_EN
        lost_mask = ~({MANTISSA_WIDTH{1'b1}} << diff1);
        if (sat) lost_mask = '1;
        aligned_next = {shifted[MANTISSA_WIDTH-1:1], shifted[0] | (|(man_small1 & lost_mask))};
`else
        aligned_next = shifted;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            big_a2   <= 1'b0;
            exp_big2 <= '0;
            man_big2 <= '0;
            aligned2 <= '0;
        end else if (s2_load) begin
            big_a2   <= big_a1;
            exp_big2 <= exp_big1;
            man_big2 <= man_big1;
            aligned2 <= aligned_next;
        end
    end

    assign bus.i_ready          = ready1;
    assign bus.o_valid          = v2;
    assign bus.o_exponent_big_a = big_a2;
    assign bus.o_exponent_big   = exp_big2;
    assign bus.mantissa_big_out = man_big2;
    assign bus.mantissa_aligned = aligned2;
endmodule

// File: tb/tb_fp7_alu_align_stage.sv
// Directed bench for fp7_alu_align_stage: vector table plus reset, latency and backpressure sequences.
// Expectations follow FP7_ALIGN_STICKY_EN when the build defines it.
module tb_fp7_alu_align_stage;
    localparam int EW = 8;
    localparam int MW = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp7_alu_align_stage_if #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW)) bus ();
    fp7_alu_align_stage #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [EW-1:0] ea;
        logic [EW-1:0] eb;
        logic [MW-1:0] ma;
        logic [MW-1:0] mb;
        logic          big_a;
        logic [EW-1:0] e_big;
        logic [MW-1:0] m_big;
        logic [MW-1:0] al_plain;
        logic [MW-1:0] al_sticky;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];
    int n_tests = 0;
    int n_fail  = 0;
    logic [2*MW-1:0] exp_q[$];

    function automatic vec_t mk(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                                input logic big_a, input logic [EW-1:0] e_big,
                                input logic [MW-1:0] m_big, input logic [MW-1:0] al_plain,
                                input logic [MW-1:0] al_sticky);
        vec_t v;
        v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
        v.big_a = big_a; v.e_big = e_big; v.m_big = m_big;
        v.al_plain = al_plain; v.al_sticky = al_sticky;
        return v;
    endfunction

    function automatic logic [MW-1:0] exp_al(input vec_t v);
`ifdef FP7_ALIGN_STICKY_EN
        return v.al_sticky;
`else
        return v.al_plain;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        bus.i_exponent_a = v.ea;
        bus.i_exponent_b = v.eb;
        bus.i_mantissa_a = v.ma;
        bus.i_mantissa_b = v.mb;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, "_big_a"}, {31'd0, bus.o_exponent_big_a}, {31'd0, v.big_a});
        check({tag, "_exp_big"}, {24'd0, bus.o_exponent_big}, {24'd0, v.e_big});
        check({tag, "_man_big"}, {8'd0, bus.mantissa_big_out}, {8'd0, v.m_big});
        check({tag, "_aligned"}, {8'd0, bus.mantissa_aligned}, {8'd0, exp_al(v)});
    endtask

    task automatic apply_vec(input int k);
        int t;
        @(negedge clk);
        bus.o_ready = 1'b1;
        bus.i_valid = 1'b1;
        drive_vec(vecs[k]);
        #1;
        t = 0;
        while (!bus.i_ready && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.i_ready) check($sformatf("v%0d_accept", k), {31'd0, bus.i_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        t = 0;
        while (!bus.o_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d_valid", k), {31'd0, bus.o_valid}, 32'd1);
        check_outputs($sformatf("v%0d", k), vecs[k]);
    endtask

    initial begin
        vecs[0]  = mk(8'd10,  8'd7,  24'h000100, 24'h000040, 1'b1, 8'd10,  24'h000100, 24'h000008, 24'h000008);
        vecs[1]  = mk(8'd3,   8'd40, 24'hFFFFFB, 24'h000123, 1'b0, 8'd40,  24'h000123, 24'hFFFFFF, 24'hFFFFFF);
        vecs[2]  = mk(8'd20,  8'd20, 24'h000007, 24'h000009, 1'b1, 8'd20,  24'h000007, 24'h000009, 24'h000009);
        vecs[3]  = mk(8'd5,   8'd9,  24'hFFFFC0, 24'h001234, 1'b0, 8'd9,   24'h001234, 24'hFFFFFC, 24'hFFFFFC);
        vecs[4]  = mk(8'd0,   8'd23, 24'h400000, 24'h000055, 1'b0, 8'd23,  24'h000055, 24'h000000, 24'h000001);
        vecs[5]  = mk(8'd40,  8'd16, 24'h0ABCDE, 24'h000001, 1'b1, 8'd40,  24'h0ABCDE, 24'h000000, 24'h000001);
        vecs[6]  = mk(8'd255, 8'd0,  24'h000010, 24'h800000, 1'b1, 8'd255, 24'h000010, 24'hFFFFFF, 24'hFFFFFF);
        vecs[7]  = mk(8'd12,  8'd10, 24'h000100, 24'h000005, 1'b1, 8'd12,  24'h000100, 24'h000001, 24'h000001);
        vecs[8]  = mk(8'd12,  8'd10, 24'h000100, 24'h000004, 1'b1, 8'd12,  24'h000100, 24'h000001, 24'h000001);
        vecs[9]  = mk(8'd12,  8'd10, 24'h000100, 24'h000006, 1'b1, 8'd12,  24'h000100, 24'h000001, 24'h000001);
        vecs[10] = mk(8'd13,  8'd10, 24'h000100, 24'h000009, 1'b1, 8'd13,  24'h000100, 24'h000001, 24'h000001);
        vecs[11] = mk(8'd13,  8'd10, 24'h000100, 24'h000010, 1'b1, 8'd13,  24'h000100, 24'h000002, 24'h000002);
        vecs[12] = mk(8'd14,  8'd10, 24'h000100, 24'h000011, 1'b1, 8'd14,  24'h000100, 24'h000001, 24'h000001);
        vecs[13] = mk(8'd11,  8'd10, 24'h000100, 24'h000002, 1'b1, 8'd11,  24'h000100, 24'h000001, 24'h000001);
        vecs[14] = mk(8'd12,  8'd10, 24'h000100, 24'h000008, 1'b1, 8'd12,  24'h000100, 24'h000002, 24'h000002);
        vecs[15] = mk(8'd12,  8'd10, 24'h000100, 24'h00000A, 1'b1, 8'd12,  24'h000100, 24'h000002, 24'h000003);
        vecs[16] = mk(8'd7,   8'd12, 24'h00000F, 24'h000200, 1'b0, 8'd12,  24'h000200, 24'h000000, 24'h000001);

        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        drive_vec(vecs[0]);

        // Reset state.
        #2 rst = 1'b1;
        #1;
        check("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
        check("rst_big_a", {31'd0, bus.o_exponent_big_a}, 32'd0);
        check("rst_exp_big", {24'd0, bus.o_exponent_big}, 32'd0);
        check("rst_man_big", {8'd0, bus.mantissa_big_out}, 32'd0);
        check("rst_aligned", {8'd0, bus.mantissa_aligned}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) apply_vec(k);

        // Asynchronous reset with two operands in flight behind a stalled output.
        @(negedge clk);
        bus.o_ready = 1'b0;
        bus.i_valid = 1'b1;
        drive_vec(vecs[0]);
        @(negedge clk);
        drive_vec(vecs[1]);
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("pre_rst_valid", {31'd0, bus.o_valid}, 32'd1);
        check("pre_rst_i_ready", {31'd0, bus.i_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("mid_rst_man_big", {8'd0, bus.mantissa_big_out}, 32'd0);
        check("mid_rst_exp_big", {24'd0, bus.o_exponent_big}, 32'd0);
        check("mid_rst_aligned", {8'd0, bus.mantissa_aligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.o_ready = 1'b1;
        @(negedge clk);
        check("post_rst_no_stale", {31'd0, bus.o_valid}, 32'd0);

        // Latency: input presented in one cycle, result valid two cycles later.
        bus.i_valid = 1'b1;
        drive_vec(vecs[2]);
        #1;
        check("lat_accept", {31'd0, bus.i_ready}, 32'd1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("lat_cycle1", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2", {31'd0, bus.o_valid}, 32'd1);
        check_outputs("lat", vecs[2]);
        @(negedge clk);
        check("lat_drained", {31'd0, bus.o_valid}, 32'd0);

        // Backpressure: 4 ops, output stalled 3 cycles once the first result shows up.
        begin
            int sent = 0;
            int got = 0;
            int stall = 0;
            int cyc = 0;
            bit saw_block = 0;
            bit hold = 0;
            logic [MW-1:0] h_al = '0;
            logic [MW-1:0] h_big = '0;
            logic [2*MW-1:0] e;
            while (got < 4 && cyc < 60) begin
                @(negedge clk);
                if (bus.o_valid && stall < 3) begin
                    bus.o_ready = 1'b0;
                    stall++;
                end else begin
                    bus.o_ready = 1'b1;
                end
                if (sent < 4) begin
                    bus.i_valid = 1'b1;
                    drive_vec(vecs[sent]);
                end else begin
                    bus.i_valid = 1'b0;
                end
                #1;
                if (hold) begin
                    check("stall_hold_aligned", {8'd0, bus.mantissa_aligned}, {8'd0, h_al});
                    check("stall_hold_man_big", {8'd0, bus.mantissa_big_out}, {8'd0, h_big});
                end
                if (sent == 2 && got == 0 && !bus.i_ready) saw_block = 1;
                if (bus.o_valid && bus.o_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL stall_extra_output: got output %0d with 0 expected pending", got);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("stall_out%0d_man_big", got), {8'd0, bus.mantissa_big_out}, {8'd0, e[2*MW-1:MW]});
                        check($sformatf("stall_out%0d_aligned", got), {8'd0, bus.mantissa_aligned}, {8'd0, e[MW-1:0]});
                    end
                    got++;
                end
                hold  = bus.o_valid && !bus.o_ready;
                h_al  = bus.mantissa_aligned;
                h_big = bus.mantissa_big_out;
                if (bus.i_valid && bus.i_ready) begin
                    exp_q.push_back({vecs[sent].m_big, exp_al(vecs[sent])});
                    sent++;
                end
                cyc++;
            end
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.o_ready = 1'b1;
            check("stall_outputs_seen", got, 32'd4);
            check("stall_inputs_sent", sent, 32'd4);
            check("stall_queue_empty", exp_q.size(), 32'd0);
            check("stall_i_ready_dropped", {31'd0, saw_block}, 32'd1);
            @(negedge clk);
            check("stall_no_duplicate", {31'd0, bus.o_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp7_alu_align_stage.md
# fp7_alu_align_stage

Exponent-compare and mantissa-alignment front end of the fp7 ALU adder path. It takes two operands, decides which has the larger exponent, and right-shifts the smaller operand's mantissa by the exponent difference. It presents the big mantissa, the aligned mantissa and the big-A flag directly to `fp7_alu_add_stage`. It is a two-stage pipeline with a valid/ready handshake on both sides.

## Interface
Parameters:
- `EXPONENT_WIDTH`, default 8, width of unsigned biased exponents.
- `MANTISSA_WIDTH`, default 24, width of signed two's-complement mantissas.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `i_valid`  in  1  input operand pair valid.
- `i_ready`  out  1  stage can accept an operand pair this cycle.
- `i_exponent_a`, `i_exponent_b`  in  `EXPONENT_WIDTH`  operand exponents.
- `i_mantissa_a`, `i_mantissa_b`  in  `MANTISSA_WIDTH` signed  operand mantissas.
- `o_valid`  out  1  output set valid.
- `o_ready`  in  1  downstream accepts this cycle.
- `o_exponent_big_a`  out  1  1 when operand A has the larger (or equal) exponent.
- `o_exponent_big`  out  `EXPONENT_WIDTH`  larger exponent, i.e. the result exponent before normalisation.
- `mantissa_big_out`  out  `MANTISSA_WIDTH` signed  mantissa of the big operand. Feeds `mantissa_big_in` downstream.
- `mantissa_aligned`  out  `MANTISSA_WIDTH` signed  shifted mantissa of the small operand.

## Operation
Stage 1 (compare), loaded on `s1_load = i_valid & i_ready`:
- `big_a = (i_exponent_a >= i_exponent_b)`. On a tie, A is big.
- `diff = big_a ? exp_a - exp_b : exp_b - exp_a`, unsigned, `EXPONENT_WIDTH` bits, never negative.
- Register `big_a`, the big exponent, the big mantissa, the small mantissa and `diff`. Set `v1`.

Stage 2 (align), loaded when `s2_load = v1 & (!v2 | o_ready)`:
- `mantissa_aligned = small >>> diff`. The shift is arithmetic, so the sign is preserved.
- If `diff >= MANTISSA_WIDTH`, the result is all sign bits: 0 for non-negative, -1 for negative.
- The big mantissa, big exponent and `big_a` pass through unchanged. Set `v2`.

Handshake:
- `i_ready = !v1 | s2_load`. This is combinational from `o_ready`; there is no skid buffer.
- `v1` clears when stage 2 consumes and no new input loads. `v2` clears on `o_ready & !s2_load`.
- While `o_valid & !o_ready`, all stage-2 outputs hold stable.
- Data registers load only when their stage loads. They are not reset-dependent beyond the values listed below.

Reset (async, `rst=1`):
- `v1`, `v2`, `o_valid` = 0.
- `o_exponent_big_a` = 0, `o_exponent_big` = 0, `mantissa_big_out` = 0, `mantissa_aligned` = 0.
- A reset mid-transfer discards any in-flight operands. There is no partial output.

## Timing
- Latency: 2 cycles from the accepting edge to `o_valid`, with no backpressure.
- Throughput: 1 operation per cycle while `o_ready=1`.
- With `o_ready=0` held, the pipeline fills 2 deep. `i_ready` drops in the cycle after stage 1 fills behind a stalled stage 2.
- Simultaneous accept and consume at stage 2 keeps `v2=1` and loads the new data.
- The combinational path `o_ready`→`i_ready` is the only through path. Downstream must not make `o_ready` depend on `i_valid`.
- `o_exponent_big_a` registered here is re-registered by `fp7_alu_add_stage`. The pair is therefore aligned with that stage's `compare_mantissa_o` one cycle later.

## Configuration
- `FP7_ALIGN_STICKY_EN` defined: stage 2 ORs all bits shifted out of the small mantissa into bit 0 of `mantissa_aligned`.
  - The sticky bit is computed on the two's-complement value.
  - For `diff >= MANTISSA_WIDTH`, sticky = OR of the whole small mantissa. For a negative operand, the result is -1 and bit 0 is already 1.
- Undefined: plain truncating arithmetic shift. Bit 0 is the shifted result only.

## Test plan
- Reset with `rst=1` mid-stream -> `o_valid=0`, all outputs 0 asynchronously. The first input after release appears 2 cycles after acceptance.
- exp_a=10, exp_b=7, man_a=0x000100, man_b=0x000040, `o_ready=1` -> 2 cycles later: `o_exponent_big_a=1`, `o_exponent_big=10`, `mantissa_big_out=0x000100`, `mantissa_aligned=0x000008`.
- exp_a=3, exp_b=40, man_a=-5 (0xFFFFFB), `MANTISSA_WIDTH=24` -> `o_exponent_big_a=0`, `mantissa_aligned=0xFFFFFF` (diff 37 ≥ 24 saturates to sign).
- Equal exponents 20/20, man_a=7, man_b=9 -> `o_exponent_big_a=1`, `mantissa_aligned=9`, `mantissa_big_out=7`.
- Stream of 4 ops with `o_ready=0` for 3 cycles after the first arrives -> `i_ready` falls after 2 ops are held, outputs stay stable, and all 4 ops exit in order with none lost or duplicated.
- With `FP7_ALIGN_STICKY_EN`: diff=2, small=0x000005 -> `mantissa_aligned=0x000001`. Without the macro, the same input gives `0x000001`. Small=0x000004 gives `0x000001` with the macro and `0x000001` without it. Small=0x000006 gives `0x000001` with the macro and `0x000001` without it. diff=3, small=0x000009 gives `0x000001` with the macro and `0x000001` without it. diff=3, small=0x000010 -> `0x000002` in both builds, since no bits are lost. diff=4, small=0x000011 -> `0x000001` both. diff=1, small=0x000002 -> `0x000001` both. diff=2, small=0x000008 -> `0x000002` both. diff=2, small=0x00000A -> `0x000003` with the macro, `0x000002` without.
